// File: rtl/password_lock_pkg.sv
// Shared constants and FSM state encoding for the password entry checker and the lock manager.
// All timing constants assume the 500 Hz system clock from clk_divider.
package password_lock_pkg;

    localparam int CLK_HZ         = 500;
    localparam int DIGIT_W        = 4;
    localparam int PASS_LEN       = 4;
    localparam int PASS_W         = PASS_LEN * DIGIT_W;
    localparam logic [PASS_W-1:0] DEFAULT_PASS = 16'h1234;
    localparam int TIMEOUT_SEC    = 10;
    localparam int TIMEOUT_CYCLES = CLK_HZ * TIMEOUT_SEC;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENTER       = 3'd1,
        CHECK       = 3'd2,
        PROG_ENTER  = 3'd3,
        PROG_COMMIT = 3'd4
    } state_e;

endpackage

// File: rtl/entry_shift_buffer.sv
// Digit shift register with a saturating digit count and an overflow flag.
// New digits enter at the LSB, so the first digit ends up as the MS digit.
module entry_shift_buffer #(
    parameter int DIGIT_W  = 4,
    parameter int PASS_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear_i,
    input  logic                        shift_i,
    input  logic [DIGIT_W-1:0]          digit_i,
    output logic [PASS_LEN*DIGIT_W-1:0] data_o,
    output logic [3:0]                  count_o,
    output logic                        overflow_o
);

    localparam int ENTRY_W = PASS_LEN * DIGIT_W;

    logic [ENTRY_W-1:0] data_q, data_d;
    logic [3:0]         count_q, count_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            data_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (shift_i) begin
            // A full buffer drops further digits but remembers it happened.
            if (count_q < 4'(PASS_LEN)) begin
                data_d  = (data_q << DIGIT_W) | ENTRY_W'(digit_i);
                count_d = count_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/password_entry_checker.sv
// Collects keypad digits, checks them against the stored password and handles re-programming.
// Optional idle-entry timeout: define PASSWORD_ENTRY_TIMEOUT_EN.
module password_entry_checker #(
    parameter int                          PASS_LEN       = password_lock_pkg::PASS_LEN,
    parameter int                          DIGIT_W        = password_lock_pkg::DIGIT_W,
    parameter logic [PASS_LEN*DIGIT_W-1:0] DEFAULT_PASS   = password_lock_pkg::DEFAULT_PASS,
    parameter int                          TIMEOUT_CYCLES = password_lock_pkg::TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    input  logic               btn_confirm,
    input  logic               btn_clear,
    input  logic               prog_en,
    input  logic               locked,
    output logic               match,
    output logic               btn_confirm_fullpass,
    output logic [3:0]         entry_count,
    output logic               prog_done,
    output logic               prog_error
);

    import password_lock_pkg::*;

    localparam int ENTRY_W = PASS_LEN * DIGIT_W;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] stored_q, stored_d;
    logic               match_q, match_d;
    logic               fullpass_q, fullpass_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               buf_clear, buf_shift;
    logic [ENTRY_W-1:0] buf_data;
    logic [3:0]         buf_count;
    logic               buf_ovf;

    logic               in_entry, quiet, prog_mode, entry_ok, entry_eq, digit_accept, timeout;

    assign in_entry  = (state_q == ENTER) || (state_q == PROG_ENTER);
    assign quiet     = !locked && !btn_clear && !btn_confirm;
    assign prog_mode = prog_en && match_q;
    assign entry_ok  = (buf_count == 4'(PASS_LEN)) && !buf_ovf;
    assign entry_eq  = entry_ok && (buf_data == stored_q);

    assign digit_accept = quiet && digit_valid &&
                          ((state_q == IDLE) || (state_q == ENTER) ||
                           (state_q == PROG_ENTER && prog_en));

`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // A digit in the same cycle restarts the idle window instead of timing out.
    assign timeout = in_entry && !digit_valid && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_cnt_d = '0;
        if (in_entry && !digit_valid && !timeout)
            idle_cnt_d = idle_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_cnt_q <= '0;
        else          idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    entry_shift_buffer #(
        .DIGIT_W (DIGIT_W),
        .PASS_LEN(PASS_LEN)
    ) u_entry_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (buf_clear),
        .shift_i   (buf_shift),
        .digit_i   (digit_in),
        .data_o    (buf_data),
        .count_o   (buf_count),
        .overflow_o(buf_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            stored_q   <= DEFAULT_PASS;
            match_q    <= 1'b0;
            fullpass_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stored_q   <= stored_d;
            match_q    <= match_d;
            fullpass_q <= fullpass_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Priority inside an entry: locked, clear, confirm, digit, timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!locked && !btn_clear) begin
                    if (btn_confirm)      state_d = prog_mode ? PROG_COMMIT : CHECK;
                    else if (digit_valid) state_d = prog_mode ? PROG_ENTER : ENTER;
                end
            end
            ENTER: begin
                if (locked || btn_clear) state_d = IDLE;
                else if (btn_confirm)    state_d = CHECK;
                else if (timeout)        state_d = IDLE;
            end
            PROG_ENTER: begin
                if (locked || !prog_en || btn_clear) state_d = IDLE;
                else if (btn_confirm)                state_d = PROG_COMMIT;
                else if (timeout)                    state_d = IDLE;
            end
            CHECK:       state_d = IDLE;
            PROG_COMMIT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Verdicts are registered on the confirm edge so match and the pulses appear together.
    always_comb begin
        buf_clear  = 1'b0;
        buf_shift  = 1'b0;
        match_d    = match_q;
        stored_d   = stored_q;
        fullpass_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;

        if (state_d == IDLE)
            buf_clear = 1'b1;

        if (state_d == CHECK) begin
            buf_clear  = 1'b1;
            match_d    = entry_eq;
            fullpass_d = 1'b1;
        end

        if (state_d == PROG_COMMIT) begin
            buf_clear = 1'b1;
            match_d   = 1'b0;
            if (entry_ok) begin
                stored_d = buf_data;
                done_d   = 1'b1;
            end else begin
                error_d  = 1'b1;
            end
        end

        if (digit_accept) begin
            buf_shift = 1'b1;
            if (state_q == IDLE) begin
                match_d = 1'b0;
                error_d = prog_en && !match_q;
            end
        end

        if (state_q == PROG_ENTER && prog_en && quiet && timeout)
            error_d = 1'b1;
    end

    assign match                = match_q;
    assign btn_confirm_fullpass = fullpass_q;
    assign entry_count          = buf_count;
    assign prog_done            = done_q;
    assign prog_error           = error_q;

endmodule
